// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, event format and frame-FSM encoding for the
// PS/2 key-stream front end.
//   PS2_PREFIX_EXT / PS2_PREFIX_BRK : prefix bytes folded into the next event
//   PS2_FRAME_BITS                  : start + 8 data + parity + stop
//   ps2_event_t                     : {ext, brk, code[7:0]}, 10 bits
//   ps2_frame_state_t               : IDLE / SHIFT / CHECK
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;
    localparam int         PS2_EVENT_W    = 10;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } ps2_frame_state_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n  : clock, async active-low reset
//   i_push      : write i_wr_data (accepted when not full, or when popping)
//   i_wr_data   : entry to write
//   i_pop       : remove head (ignored when empty)
//   o_rd_data   : head entry, valid whenever o_empty=0
//   o_full      : DEPTH entries held
//   o_empty     : no entries held
//   o_count     : occupancy, 0..DEPTH
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_pop;
    logic w_push;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // When full, a simultaneous pop frees the head slot, which is exactly
    // where the write pointer sits, so the write is safe.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // Memory is cleared on reset so the head outputs are never X while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/ps2_key_stream.sv
// ps2_key_stream: PS/2 keyboard front end producing a buffered key-event
// stream.
//   clk, rst_n   : system clock, async active-low reset
//   kclk, kdata  : raw PS/2 pins (asynchronous)
//   rd_en        : pop head event (ignored when key_valid=0)
//   key_valid    : event FIFO non-empty
//   key_code     : head scan code
//   key_release  : head event was F0-prefixed
//   key_extended : head event was E0-prefixed
//   parity_err   : one-cycle pulse, frame rejected
//   overflow     : one-cycle pulse, event dropped on full FIFO
//   fifo_count   : FIFO occupancy
//
// Frame FSM
//   state    | meaning
//   IDLE     | waiting for a start bit (falling kclk with kdata=0)
//   SHIFT    | collecting data, parity and stop bits; timer guards stalls
//   CHECK    | one cycle: validate frame, hand byte to prefix decoder
module ps2_key_stream
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          kclk,
    input  logic                          kdata,
    input  logic                          rd_en,
    output logic                          key_valid,
    output logic [7:0]                    key_code,
    output logic                          key_release,
    output logic                          key_extended,
    output logic                          parity_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMR_RELOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      LAST_BIT   = 4'(PS2_FRAME_BITS - 2);

    logic r_kclk_s1, r_kclk_s2, r_kclk_prev;
    logic r_kdata_s1, r_kdata_s2;
    logic w_fall;

    ps2_frame_state_t r_state;
    logic [3:0]       r_bit_cnt;
    logic [9:0]       r_shift;
    logic [TW-1:0]    r_timer;
    logic             r_byte_vld;
    logic [7:0]       r_byte;
    logic             r_parity_err;

    logic             r_ext;
    logic             r_brk;
    logic             w_is_prefix;
    logic             w_push;
    ps2_event_t       w_push_ev;
    ps2_event_t       w_head;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             r_overflow;

    // Synchronisers idle high so reset cannot fake a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kclk_s1   <= 1'b1;
            r_kclk_s2   <= 1'b1;
            r_kclk_prev <= 1'b1;
            r_kdata_s1  <= 1'b1;
            r_kdata_s2  <= 1'b1;
        end else begin
            r_kclk_s1   <= kclk;
            r_kclk_s2   <= r_kclk_s1;
            r_kclk_prev <= r_kclk_s2;
            r_kdata_s1  <= kdata;
            r_kdata_s2  <= r_kdata_s1;
        end
    end

    assign w_fall = r_kclk_prev && !r_kclk_s2;

    // Bits enter at the top and move down, so after ten edges
    // r_shift = {stop, parity, data[7:0]}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_timer      <= '0;
            r_byte_vld   <= 1'b0;
            r_byte       <= '0;
            r_parity_err <= 1'b0;
        end else begin
            r_byte_vld   <= 1'b0;
            r_parity_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall && !r_kdata_s2) begin
                        r_state   <= ST_SHIFT;
                        r_bit_cnt <= '0;
                        r_timer   <= TMR_RELOAD;
                    end
                end
                ST_SHIFT: begin
                    if (w_fall) begin
                        r_shift <= {r_kdata_s2, r_shift[9:1]};
                        r_timer <= TMR_RELOAD;
                        if (r_bit_cnt == LAST_BIT) r_state <= ST_CHECK;
                        else r_bit_cnt <= r_bit_cnt + 1'b1;
                    end else if (r_timer == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if ((^r_shift[8:0]) && r_shift[9]) begin
                        r_byte_vld <= 1'b1;
                        r_byte     <= r_shift[7:0];
                    end else begin
                        r_parity_err <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_is_prefix = (r_byte == PS2_PREFIX_EXT) || (r_byte == PS2_PREFIX_BRK);
    assign w_push      = r_byte_vld && !w_is_prefix;
    assign w_push_ev   = '{ext: r_ext, brk: r_brk, code: r_byte};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (r_parity_err) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (r_byte_vld) begin
            if (r_byte == PS2_PREFIX_EXT) begin
                r_ext <= 1'b1;
            end else if (r_byte == PS2_PREFIX_BRK) begin
                r_brk <= 1'b1;
            end else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_EVENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_wr_data (w_push_ev),
        .i_pop     (rd_en),
        .o_rd_data (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_overflow <= 1'b0;
        else        r_overflow <= w_push && w_fifo_full && !(rd_en && !w_fifo_empty);
    end

    assign key_valid    = !w_fifo_empty;
    assign key_code     = w_head.code;
    assign key_release  = w_head.brk;
    assign key_extended = w_head.ext;
    assign parity_err   = r_parity_err;
    assign overflow     = r_overflow;

endmodule
